// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the 8-bit RISC pipeline.
// Holds the opcode map, instruction field positions, datapath defaults and
// the decode-stage state encoding. No ports.
package risc_pkg;

    // Datapath defaults
    localparam int DATA_W_DEF = 8;
    localparam int NREG_DEF   = 8;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes: 0x0..OP_ALU_MAX are passed straight to the ALU
    localparam logic [3:0] OP_ALU_MAX = 4'h9;
    localparam logic [3:0] OP_LDI     = 4'hA;
    localparam logic [3:0] OP_JMP     = 4'hB;
    localparam logic [3:0] OP_BZ      = 4'hC;
    localparam logic [3:0] OP_BN      = 4'hD;
    localparam logic [3:0] OP_NOP     = 4'hE;
    localparam logic [3:0] OP_HALT    = 4'hF;
    localparam logic [3:0] ALU_ADD    = 4'h0;

    // Decode-stage states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLAGWAIT = 2'd1,
        FLUSH    = 2'd2,
        HALTED   = 2'd3
    } id_state_t;

    // Branch condition: BN tests the N flag, BZ tests the Z flag
    function automatic logic branch_cond(input logic is_bn, input logic gn, input logic gz);
        return is_bn ? gn : gz;
    endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: NREG x DATA_W register file, one write port, two combinational
// read ports. A read of the address being written in the same cycle returns
// the write data. Cleared by synchronous active-low reset; writes are
// ignored while reset is asserted.
// Ports: clk, rst, we/waddr/wdata (write), raddr_a/raddr_b -> rdata_a/rdata_b.
module reg_file
    import risc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [DATA_W-1:0]       rdata_a,
    output logic [DATA_W-1:0]       rdata_b
);

    logic [DATA_W-1:0] mem_r [NREG];

    // Register storage: reset clears every entry, otherwise one write per cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read ports with write-through bypass
    always_comb begin
        rdata_a = mem_r[raddr_a];
        rdata_b = mem_r[raddr_b];
        if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem_r[raddr_a];
        end
        if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem_r[raddr_b];
        end
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode stage. Accepts instructions from fetch,
// reads operands (EXE forward > WB bypass > register file), loads the ID/EXE
// register and resolves branches against the execute stage's N/Z flags,
// waiting one cycle when the instruction in ID/EXE is still producing them.
// Ports: if_valid/if_instr/id_ready (fetch handshake), wb_* (writeback),
// OALUD/IFgn/IFgz (execute feedback), Ira/Irb/OPALU/NFCR/ZFCR/exe_rd/exe_wen
// (ID/EXE register), br_taken/br_target (redirect), halted.
module id_stage
    import risc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_valid,
    input  logic [15:0]             if_instr,
    output logic                    id_ready,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic [DATA_W-1:0]       OALUD,
    input  logic                    IFgn,
    input  logic                    IFgz,
    output logic [DATA_W-1:0]       Ira,
    output logic [DATA_W-1:0]       Irb,
    output logic [3:0]              OPALU,
    output logic                    NFCR,
    output logic                    ZFCR,
    output logic [$clog2(NREG)-1:0] exe_rd,
    output logic                    exe_wen,
    output logic                    br_taken,
    output logic [7:0]              br_target,
    output logic                    halted
);

    localparam int AW = $clog2(NREG);

    id_state_t         state_r;
    logic              held_is_bn_r;
    logic [7:0]        held_target_r;

    logic              xfer_s;
    logic [3:0]        op_s;
    logic [AW-1:0]     rd_s;
    logic [AW-1:0]     ra_s;
    logic [AW-1:0]     rb_s;
    logic [7:0]        imm_s;
    logic [DATA_W-1:0] rf_a_s;
    logic [DATA_W-1:0] rf_b_s;
    logic [DATA_W-1:0] opnd_a_s;
    logic [DATA_W-1:0] opnd_b_s;

    assign op_s   = if_instr[OP_MSB:OP_LSB];
    assign rd_s   = if_instr[RD_MSB:RD_LSB];
    assign ra_s   = if_instr[RA_MSB:RA_LSB];
    assign rb_s   = if_instr[RB_MSB:RB_LSB];
    assign imm_s  = if_instr[IMM_MSB:IMM_LSB];

    assign id_ready = (state_r == RUN) || (state_r == FLUSH);
    assign xfer_s   = if_valid && id_ready;

    reg_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (ra_s),
        .raddr_b (rb_s),
        .rdata_a (rf_a_s),
        .rdata_b (rf_b_s)
    );

    // Operand select: the result now in execute beats the register file path
    // (which already carries the writeback bypass)
    always_comb begin
        opnd_a_s = rf_a_s;
        opnd_b_s = rf_b_s;
        if (exe_wen && (exe_rd == ra_s)) begin
            opnd_a_s = OALUD;
        end else begin
            opnd_a_s = rf_a_s;
        end
        if (exe_wen && (exe_rd == rb_s)) begin
            opnd_b_s = OALUD;
        end else begin
            opnd_b_s = rf_b_s;
        end
    end

    // Decode FSM and ID/EXE register; every cycle starts from a bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= RUN;
            held_is_bn_r  <= 1'b0;
            held_target_r <= 8'h00;
            Ira           <= '0;
            Irb           <= '0;
            OPALU         <= 4'h0;
            NFCR          <= 1'b0;
            ZFCR          <= 1'b0;
            exe_rd        <= '0;
            exe_wen       <= 1'b0;
            br_taken      <= 1'b0;
            br_target     <= 8'h00;
            halted        <= 1'b0;
        end else begin
            Ira       <= '0;
            Irb       <= '0;
            OPALU     <= 4'h0;
            NFCR      <= 1'b0;
            ZFCR      <= 1'b0;
            exe_rd    <= '0;
            exe_wen   <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= 8'h00;
            case (state_r)
                RUN: begin
                    if (xfer_s) begin
                        case (op_s)
                            OP_LDI: begin
                                Ira     <= DATA_W'(imm_s);
                                OPALU   <= ALU_ADD;
                                exe_rd  <= rd_s;
                                exe_wen <= 1'b1;
                            end
                            OP_JMP: begin
                                br_taken  <= 1'b1;
                                br_target <= imm_s;
                                state_r   <= FLUSH;
                            end
                            OP_BZ, OP_BN: begin
                                // Flags are stale while the ID/EXE instruction updates them
                                if (NFCR || ZFCR) begin
                                    held_is_bn_r  <= (op_s == OP_BN);
                                    held_target_r <= imm_s;
                                    state_r       <= FLAGWAIT;
                                end else if (branch_cond(op_s == OP_BN, IFgn, IFgz)) begin
                                    br_taken  <= 1'b1;
                                    br_target <= imm_s;
                                    state_r   <= FLUSH;
                                end else begin
                                    state_r <= RUN;
                                end
                            end
                            OP_NOP: begin
                                state_r <= RUN;
                            end
                            OP_HALT: begin
                                halted  <= 1'b1;
                                state_r <= HALTED;
                            end
                            default: begin
                                if (op_s <= OP_ALU_MAX) begin
                                    Ira     <= opnd_a_s;
                                    Irb     <= opnd_b_s;
                                    OPALU   <= op_s;
                                    NFCR    <= 1'b1;
                                    ZFCR    <= 1'b1;
                                    exe_rd  <= rd_s;
                                    exe_wen <= 1'b1;
                                end else begin
                                    state_r <= RUN;
                                end
                            end
                        endcase
                    end else begin
                        state_r <= RUN;
                    end
                end
                FLAGWAIT: begin
                    if (branch_cond(held_is_bn_r, IFgn, IFgz)) begin
                        br_taken  <= 1'b1;
                        br_target <= held_target_r;
                        state_r   <= FLUSH;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FLUSH: begin
                    // Whatever fetch hands over now is on the wrong path
                    state_r <= RUN;
                end
                HALTED: begin
                    halted  <= 1'b1;
                    state_r <= HALTED;
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage. Each cycle the bench drives
// fetch/writeback/execute inputs, predicts the ID/EXE register contents with
// a behavioural model, queues the prediction and compares it after the edge.
module tb_id_stage;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        id_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [7:0]  OALUD;
    logic        IFgn, IFgz;
    logic [7:0]  Ira, Irb;
    logic [3:0]  OPALU;
    logic        NFCR, ZFCR;
    logic [2:0]  exe_rd;
    logic        exe_wen;
    logic        br_taken;
    logic [7:0]  br_target;
    logic        halted;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .id_ready(id_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .OALUD(OALUD), .IFgn(IFgn), .IFgz(IFgz), .Ira(Ira), .Irb(Irb),
        .OPALU(OPALU), .NFCR(NFCR), .ZFCR(ZFCR), .exe_rd(exe_rd),
        .exe_wen(exe_wen), .br_taken(br_taken), .br_target(br_target),
        .halted(halted)
    );

    typedef struct packed {
        logic [7:0] ira;
        logic [7:0] irb;
        logic [3:0] op;
        logic       nf;
        logic       zf;
        logic [2:0] rd;
        logic       wen;
        logic       br;
        logic [7:0] tgt;
        logic       hlt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state (0 RUN, 1 FLAGWAIT, 2 FLUSH, 3 HALTED)
    logic [7:0] m_reg [8];
    int         m_st = 0;
    exp_t       m_cur = '0;
    logic       m_hbn = 1'b0;
    logic [7:0] m_htgt = 8'h00;
    bit         m_known = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a, input logic [7:0] alud,
                                          input logic we, input logic [2:0] wa, input logic [7:0] wd);
        if (m_cur.wen && m_cur.rd == a) return alud;
        if (we && wa == a) return wd;
        return m_reg[a];
    endfunction

    task automatic cyc(input logic v, input logic [15:0] ins, input logic [7:0] alud = 8'h00,
                       input logic gz = 1'b0, input logic gn = 1'b0, input logic we = 1'b0,
                       input logic [2:0] wa = 3'd0, input logic [7:0] wd = 8'h00,
                       input logic r = 1'b1);
        exp_t n;
        exp_t got;
        exp_t e;
        logic rdy;
        logic [3:0] op;
        @(negedge clk);
        rst = r; if_valid = v; if_instr = ins; OALUD = alud;
        IFgz = gz; IFgn = gn; wb_en = we; wb_addr = wa; wb_data = wd;
        rdy = (m_st == 0) || (m_st == 2);
        if (m_known) check_val("id_ready", {63'd0, id_ready}, {63'd0, rdy});
        n = '0;
        op = ins[15:12];
        if (!r) begin
            m_st = 0;
            for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
            m_known = 1'b1;
        end else begin
            case (m_st)
                0: if (v) begin
                    if (op <= 4'h9) begin
                        n.ira = m_read(ins[8:6], alud, we, wa, wd);
                        n.irb = m_read(ins[5:3], alud, we, wa, wd);
                        n.op = op; n.nf = 1'b1; n.zf = 1'b1; n.rd = ins[11:9]; n.wen = 1'b1;
                    end else if (op == 4'hA) begin
                        n.ira = ins[7:0]; n.rd = ins[11:9]; n.wen = 1'b1;
                    end else if (op == 4'hB) begin
                        n.br = 1'b1; n.tgt = ins[7:0]; m_st = 2;
                    end else if (op == 4'hC || op == 4'hD) begin
                        if (m_cur.nf || m_cur.zf) begin
                            m_st = 1; m_hbn = (op == 4'hD); m_htgt = ins[7:0];
                        end else if ((op == 4'hD) ? gn : gz) begin
                            n.br = 1'b1; n.tgt = ins[7:0]; m_st = 2;
                        end
                    end else if (op == 4'hF) begin
                        n.hlt = 1'b1; m_st = 3;
                    end
                end
                1: begin
                    if (m_hbn ? gn : gz) begin
                        n.br = 1'b1; n.tgt = m_htgt; m_st = 2;
                    end else begin
                        m_st = 0;
                    end
                end
                2: m_st = 0;
                default: n.hlt = 1'b1;
            endcase
            if (we) m_reg[wa] = wd;
        end
        m_cur = n;
        exp_q.push_back(n);
        @(posedge clk);
        #1;
        got = {Ira, Irb, OPALU, NFCR, ZFCR, exe_rd, exe_wen, br_taken, br_target, halted};
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("id_exe", {28'd0, got}, {28'd0, e});
        end
    endtask

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_instr = 16'h0000; OALUD = 8'h00;
        IFgn = 1'b0; IFgz = 1'b0; wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;

        // Reset
        cyc(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cyc(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        // LDI, then EXE forwarding, then EXE forward beating WB
        cyc(1'b1, enc_i(OP_LDI, 3'd1, 8'h5A));
        cyc(1'b1, enc_r(4'h1, 3'd2, 3'd1, 3'd1), 8'h5A);
        cyc(1'b1, enc_i(OP_LDI, 3'd1, 8'h5A));
        cyc(1'b1, enc_r(4'h1, 3'd2, 3'd1, 3'd1), 8'h5A, 1'b0, 1'b0, 1'b1, 3'd1, 8'h33);
        // ALU then BZ: flag wait, taken, flushed successor
        cyc(1'b1, enc_r(4'h0, 3'd3, 3'd1, 3'd2), 8'h10);
        cyc(1'b1, enc_i(OP_BZ, 3'd0, 8'h40));
        cyc(1'b1, enc_r(4'h2, 3'd4, 3'd1, 3'd1), 8'h00, 1'b1);
        cyc(1'b1, enc_r(4'h2, 3'd4, 3'd1, 3'd1));
        // BN after NOP not taken; JMP after ALU
        cyc(1'b1, enc_i(OP_NOP, 3'd0, 8'h00));
        cyc(1'b1, enc_i(OP_BN, 3'd0, 8'h20));
        cyc(1'b1, enc_r(4'h3, 3'd4, 3'd1, 3'd1));
        cyc(1'b1, enc_i(OP_JMP, 3'd0, 8'h10));
        cyc(1'b1, enc_r(4'h4, 3'd4, 3'd1, 3'd1));
        // Register file read and same-cycle WB bypass
        cyc(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h77);
        cyc(1'b1, enc_r(4'h3, 3'd0, 3'd5, 3'd5));
        cyc(1'b1, enc_r(4'h4, 3'd7, 3'd6, 3'd5), 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 8'h99);
        // Unstalled taken BZ, then BN waiting on flags and resolving taken
        cyc(1'b1, enc_i(OP_NOP, 3'd0, 8'h00));
        cyc(1'b1, enc_i(OP_BZ, 3'd0, 8'h55), 8'h00, 1'b1);
        cyc(1'b1, enc_i(OP_LDI, 3'd2, 8'hAA));
        cyc(1'b1, enc_r(4'h9, 3'd1, 3'd2, 3'd5));
        cyc(1'b1, enc_i(OP_BN, 3'd0, 8'h21));
        cyc(1'b1, enc_i(OP_LDI, 3'd2, 8'hAA), 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000);
        // HALT, stuck, reset releases
        cyc(1'b1, enc_i(OP_HALT, 3'd0, 8'h00));
        for (int i = 0; i < 3; i++) cyc(1'b1, enc_i(OP_LDI, 3'd1, 8'h01));
        cyc(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        cyc(1'b1, enc_i(OP_LDI, 3'd2, 8'h11));
        // Reset during FLAGWAIT with a WB write pending
        cyc(1'b1, enc_r(4'h5, 3'd3, 3'd2, 3'd2), 8'h11);
        cyc(1'b1, enc_i(OP_BN, 3'd0, 8'h66));
        cyc(1'b1, enc_i(OP_LDI, 3'd1, 8'h01), 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 8'hEE, 1'b0);
        cyc(1'b1, enc_r(4'h6, 3'd5, 3'd4, 3'd4));
        cyc(1'b0, 16'h0000);
        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
                1'($urandom_range(0, 15) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 8-bit RISC pipeline, directly upstream of the execute stage. Accepts 16-bit instructions from fetch, reads an 8×8 register file, and forwards from the execute result and the writeback port. Loads the ID/EXE pipeline register that drives the ALU operands, ALU opcode and flag-register enables. Resolves branches against the execute stage's N/Z flag registers, stalling one cycle when the flags are still being produced.

## Interface
- DATA_W, 8: datapath and register width.
- NREG, 8: register count; register address width is 3.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  16  instruction word.
- id_ready  out  1  ID accepts `if_instr` this cycle (transfer = `if_valid & id_ready`).
- wb_en  in  1  register-file write enable.
- wb_addr  in  3  write address.
- wb_data  in  8  write data.
- OALUD  in  8  execute-stage ALU result for the instruction now in ID/EXE.
- IFgn, IFgz  in  1  execute-stage N/Z flag-register outputs.
- Ira, Irb  out  8  registered ALU operands.
- OPALU  out  4  registered ALU opcode.
- NFCR, ZFCR  out  1  registered N/Z flag-register enables.
- exe_rd  out  3  registered destination register.
- exe_wen  out  1  registered writeback enable.
- br_taken  out  1  registered one-cycle redirect pulse to fetch.
- br_target  out  8  registered absolute branch target.
- halted  out  1  HALT retired; held until reset.

## Operation
- Format: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [7:0] imm8 (LDI/JMP/BZ/BN).
- op 0x0–0x9 (ALU): Ira=R[ra], Irb=R[rb], OPALU=op, exe_wen=1, NFCR=ZFCR=1.
- op 0xA LDI: Ira=imm8, Irb=0, OPALU=ALU_ADD (0x0), exe_wen=1, NFCR=ZFCR=0.
- op 0xB JMP: always taken. op 0xC BZ: taken if IFgz=1. op 0xD BN: taken if IFgn=1.
- op 0xE NOP. op 0xF HALT.
- Branches, NOP and HALT load a bubble.
- Bubble: all ID/EXE fields 0. Also loaded when no transfer occurs.
- Operand source priority: EXE forward (exe_wen & exe_rd==addr → OALUD), then WB bypass (wb_en & wb_addr==addr → wb_data), then register file.
- Register file: all 8 registers writable. Cleared to 0 on reset. wb writes ignored while rst=0.
- States:
  - RUN: id_ready=1.
    - Branch accepted while ID/EXE has NFCR|ZFCR=1 (JMP exempt) → FLAGWAIT. The branch is held internally.
    - Branch resolved taken → FLUSH. Not taken → stay in RUN.
    - HALT → HALTED.
  - FLAGWAIT: id_ready=0, bubble loaded. Next cycle the held branch resolves from IFgn/IFgz → FLUSH if taken, else RUN.
  - FLUSH: id_ready=1. A transferred instruction is discarded (bubble) → RUN.
  - HALTED: id_ready=0, bubbles, halted=1. Exit only by reset.

## Timing
- Reset (rst=0 at edge): state RUN, every registered output 0, registers 0. id_ready=1 in the first cycle after reset.
- Reset mid-operation discards any held branch, FLUSH or HALTED state.
- Decode latency 1: an instruction transferred in cycle N appears on Ira/Irb/OPALU/NFCR/ZFCR/exe_rd/exe_wen in cycle N+1.
- Branch resolved in cycle N → br_taken=1 and br_target valid in N+1 only. The instruction transferred in N+1 is discarded. Fetch presents the target from N+2.
- FLAGWAIT costs exactly one bubble cycle.
- Simultaneous EXE forward and WB to the same address: EXE forward wins.
- WB write and read of the same address in one cycle returns wb_data.

## Structure
- Shared package `risc_pkg`: opcode constants (ALU range 0x0–0x9, LDI, JMP, BZ, BN, NOP, HALT), ALU_ADD, instruction field positions, DATA_W/NREG defaults, and the ID state encoding (RUN, FLAGWAIT, FLUSH, HALTED).
- One sub-module `reg_file`: 8×8, one write port, two combinational read ports with write-through bypass.

## Test plan
- Reset, then transfer LDI r1,0x5A → the next cycle shows Ira=0x5A, Irb=0, OPALU=0, exe_wen=1, exe_rd=1, NFCR=ZFCR=0.
- R-type 0x1 r2,r1,r1 immediately after LDI r1,0x5A with OALUD=0x5A → Ira=Irb=0x5A via EXE forward. Repeat with wb_en=1, wb_addr=1, wb_data=0x33 in the same cycle → still 0x5A.
- ALU op followed by BZ 0x40 → id_ready=0 for one cycle (bubble). With IFgz=1 on the next cycle, br_taken=1 and br_target=0x40. The following transferred instruction produces a bubble.
- BN 0x20 after a NOP with IFgn=0 → no stall, br_taken stays 0, state RUN. JMP 0x10 after an ALU op → no stall, br_taken=1 the next cycle.
- HALT → halted=1 and id_ready=0 thereafter, with bubbles on all outputs. Drive rst=0 for one edge → halted=0, id_ready=1, all outputs 0.
- Drive rst=0 while in FLAGWAIT with wb_en=1 → no register write, no br_taken pulse, state RUN after reset.
